sine_dds_addr_gen: RTL
======================

Name: sine_dds_addr_gen

Overview:
Direct-digital-synthesis phase accumulator that generates the read address stream for the 1024-entry, 8-bit sine table RAM (HIGH_PERFORMANCE mode, 2-cycle read latency).
It replaces a free-running address counter with a programmable frequency tuning word (FTW).
It also emits a valid strobe aligned to the RAM output, so downstream logic knows which douta samples are real.

Parameters:
PHASE_W, 32, accumulator width in bits.
ADDR_W, 11, width of the addra output; matches the RAM address port.
TBL_LOG2, 10, log2 of table depth; addra carries acc[PHASE_W-1 -: TBL_LOG2], zero-extended.
RAM_LATENCY, 2, RAM read latency in clocks; sets the sample_valid delay.
DEFAULT_FTW, 32'h0040_0000, tuning word after reset; advances one table entry per clock.
SYNC_LOAD, 1, selects when a new FTW takes effect: 1 = at the next phase wrap (glitch-free); 0 = on the next clock.

Ports:
clka  in  1  clock; all logic is on the rising edge.
rsta  in  1  reset; synchronous, active-high.
en  in  1  run enable; when low the accumulator holds.
phase_clr  in  1  synchronous phase zero command.
ftw_data  in  PHASE_W  new tuning word.
ftw_valid  in  1  ftw_data is offered.
ftw_ready  out  1  block can accept a new tuning word.
addra  out  ADDR_W  RAM read address.
ena  out  1  RAM enable; high while running.
wrap  out  1  one-cycle pulse on accumulator carry-out.
sample_valid  out  1  RAM douta is valid on this cycle.

Behaviour:
- Reset, while rsta is high at an edge:
  - acc=0; ftw_active=DEFAULT_FTW; pending FTW cleared.
  - Outputs: addra=0, ena=0, wrap=0, sample_valid=0, ftw_ready=0.
  - ftw_ready rises on the first edge after rsta falls.
- Reset mid-operation discards any pending FTW and flushes the valid pipe.
- State machine has three states:
  - IDLE: en=0. Transitions to RUN when en=1.
  - RUN: no FTW pending.
  - PEND: FTW accepted, waiting to be applied. Only reachable when SYNC_LOAD=1.
  - Any state drops back to IDLE when en=0; an existing pending FTW is retained.
- ftw_ready is 1 in IDLE and RUN, 0 in PEND.
  - A handshake completes on an edge where ftw_valid and ftw_ready are both high.
- With SYNC_LOAD=0, an accepted word is copied to ftw_active on the next edge and the state stays RUN.
- With SYNC_LOAD=1, the accepted word goes to ftw_pend:
  - It is copied to ftw_active on the first later edge where the add carries out, or where phase_clr is taken.
  - The state then returns to RUN.
  - A word accepted on the same edge as a carry waits for the next carry.
- Accumulator, per edge with en=1:
  - acc <= (acc + ftw_active) mod 2^PHASE_W.
  - wrap <= carry-out of that add.
  - With en=0, acc holds and wrap <= 0.
- phase_clr has priority over the increment:
  - acc <= 0 and wrap <= 0.
  - Any pending FTW is applied on that edge.
- addra = {0, acc[PHASE_W-1 -: TBL_LOG2]}. It comes straight from the acc register; there is no combinational path from the inputs.
- ena is a register that follows en with 1 cycle of delay, so ena and addra change on the same edge.
- The valid pipe is RAM_LATENCY stages: stage0 <= ena, then stage i <= stage i-1, and sample_valid = the last stage.
  - sample_valid is high exactly RAM_LATENCY cycles after the RAM sampled an address with ena=1.
- An FTW of 0 is legal: addra is constant, and sample_valid still asserts while running.

Decomposition:
- Package dds_pkg holds:
  - the PHASE_W, TBL_LOG2 and DEFAULT_FTW constants;
  - the state enum {IDLE, RUN, PEND};
  - a phase_t typedef (logic [PHASE_W-1:0]).
- One sub-module, valid_delay_line (parameter DEPTH), implements the sample_valid pipe and is reusable for other RAM latencies.

Test Plan:
- Release rsta, hold en=1 with the default FTW:
  - addra steps 0,1,2,…,1023,0.
  - wrap pulses one cycle, on the edge where addra goes 1023->0.
  - sample_valid first rises 2 cycles after ena first rises.
- With SYNC_LOAD=0, load FTW 0x0080_0000 while at addra=100: the sequence continues 101,103,105 (step 2 from the next edge).
- With SYNC_LOAD=1, load FTW 0x0020_0000 at addra=500:
  - ftw_ready drops.
  - Step stays 1 until the wrap; after it addra runs 0, then advances 1 entry every 2 clocks.
  - ftw_ready returns high at the wrap.
- Assert ftw_valid on two consecutive cycles while SYNC_LOAD=1: the first word is accepted, the second is held off (ftw_ready=0) until the wrap, then accepted.
- Pulse phase_clr at addra=300 while a word is pending: addra becomes 0, the pending word takes effect, wrap stays 0, ftw_ready returns to 1.
- Assert rsta for 1 cycle mid-run with a word pending: all outputs return to reset values, the pending word is dropped, and the step returns to DEFAULT_FTW.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and types for the sine-table DDS address generator.
package dds_pkg;

   localparam int                PHASE_W     = 32;
   localparam int                TBL_LOG2    = 10;
   localparam logic [31:0]       DEFAULT_FTW = 32'h0040_0000;

   typedef logic [PHASE_W-1:0] phase_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } dds_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that delays a strobe by DEPTH clocks; flushed by reset.
module valid_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] pipe_r;

   // Strobe shift chain, stage 0 takes the input.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_r <= {DEPTH{1'b0}};
      end else begin
         pipe_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/sine_dds_addr_gen.sv
// DDS phase accumulator producing sine-table RAM addresses, with a tuning-word
// handshake and a valid strobe aligned to the RAM read data.
module sine_dds_addr_gen #(
   parameter int                        PHASE_W     = dds_pkg::PHASE_W,
   parameter int                        ADDR_W      = 11,
   parameter int                        TBL_LOG2    = dds_pkg::TBL_LOG2,
   parameter int                        RAM_LATENCY = 2,
   parameter logic [PHASE_W-1:0]        DEFAULT_FTW = dds_pkg::DEFAULT_FTW,
   parameter int                        SYNC_LOAD   = 1
) (
   input  logic               clka,
   input  logic               rsta,
   input  logic               en,
   input  logic               phase_clr,
   input  logic [PHASE_W-1:0] ftw_data,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   output logic [ADDR_W-1:0]  addra,
   output logic               ena,
   output logic               wrap,
   output logic               sample_valid
);

   import dds_pkg::*;

   localparam bit SYNC_EN = (SYNC_LOAD != 0);

   logic [PHASE_W-1:0] acc_r;
   logic [PHASE_W-1:0] ftw_active_r;
   logic [PHASE_W-1:0] ftw_pend_r;
   logic               pend_valid_r;
   logic               pend_valid_s;
   dds_state_e         state_r;
   dds_state_e         state_s;
   logic               ftw_ready_r;
   logic               wrap_r;
   logic               ena_r;
   logic [PHASE_W:0]   sum_s;
   logic               carry_s;
   logic               accept_s;
   logic               apply_s;

   assign sum_s    = {1'b0, acc_r} + {1'b0, ftw_active_r};
   assign carry_s  = sum_s[PHASE_W];
   assign accept_s = ftw_valid & ftw_ready_r;

   // Pending-word bookkeeping and next-state selection.
   always_comb begin
      apply_s      = 1'b0;
      pend_valid_s = pend_valid_r;
      state_s      = state_r;

      // A held word lands on a carry or a phase clear, never on its own accept edge.
      if (SYNC_EN) begin
         apply_s = pend_valid_r & (phase_clr | (en & carry_s));
      end else begin
         apply_s = 1'b0;
      end

      if (accept_s && SYNC_EN) begin
         pend_valid_s = 1'b1;
      end else if (apply_s) begin
         pend_valid_s = 1'b0;
      end else begin
         pend_valid_s = pend_valid_r;
      end

      case (state_r)
         IDLE: begin
            if (!en) begin
               state_s = IDLE;
            end else if (pend_valid_s) begin
               state_s = PEND;
            end else begin
               state_s = RUN;
            end
         end
         RUN, PEND: begin
            if (!en) begin
               state_s = IDLE;
            end else if (pend_valid_s) begin
               state_s = PEND;
            end else begin
               state_s = RUN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Control state, tuning-word registers and handshake ready.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_r      <= IDLE;
         pend_valid_r <= 1'b0;
         ftw_pend_r   <= {PHASE_W{1'b0}};
         ftw_active_r <= DEFAULT_FTW;
         ftw_ready_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         pend_valid_r <= pend_valid_s;
         ftw_ready_r  <= (state_s != PEND);
         if (accept_s && SYNC_EN) begin
            ftw_pend_r <= ftw_data;
         end
         if (apply_s) begin
            ftw_active_r <= ftw_pend_r;
         end else if (accept_s && !SYNC_EN) begin
            ftw_active_r <= ftw_data;
         end
      end
   end

   // Phase accumulator, carry pulse and RAM enable.
   always_ff @(posedge clka) begin
      if (rsta) begin
         acc_r  <= {PHASE_W{1'b0}};
         wrap_r <= 1'b0;
         ena_r  <= 1'b0;
      end else begin
         ena_r <= en;
         if (phase_clr) begin
            acc_r  <= {PHASE_W{1'b0}};
            wrap_r <= 1'b0;
         end else if (en) begin
            acc_r  <= sum_s[PHASE_W-1:0];
            wrap_r <= carry_s;
         end else begin
            wrap_r <= 1'b0;
         end
      end
   end

   valid_delay_line #(
      .DEPTH (RAM_LATENCY)
   ) u_valid_delay (
      .clk  (clka),
      .rst  (rsta),
      .din  (ena_r),
      .dout (sample_valid)
   );

   assign addra     = {{(ADDR_W-TBL_LOG2){1'b0}}, acc_r[PHASE_W-1 -: TBL_LOG2]};
   assign ena       = ena_r;
   assign wrap      = wrap_r;
   assign ftw_ready = ftw_ready_r;

endmodule
